// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types for the sram-like request arbiter:
//   arb_state_e : arbiter FSM states (IDLE / REQ / RESP)
//   owner_e     : which requester owns the shared port (OWN_INST=0, OWN_DATA=1)
//   SIZE_*      : sram-like transfer size encodings
//   starve_cnt_w: width of the optional starvation counter
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Enough bits to hold the value `limit` itself, so the counter can saturate
  // exactly at the limit.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage : arb_pkg

// File: rtl/arb_grant.sv
// -----------------------------------------------------------------------------
// arb_grant
// Picks the next owner of the shared memory port from the two pending
// requests. Data has fixed priority over instruction fetch.
//
// Optional feature (macro ARB_STARVE_GUARD_EN): a saturating counter tracks
// consecutive data grants made while a fetch was waiting; once it reaches
// STARVE_LIMIT the next arbitration goes to the fetch regardless of data_req.
// Without the macro the counter (and the clock/reset ports) do not exist.
//
// Ports:
//   clock, reset  : only present with ARB_STARVE_GUARD_EN (counter state)
//   inst_req      : fetch request pending
//   data_req      : data request pending
//   grant_en      : an arbitration decision is being taken this cycle
//   grant_valid   : at least one request is pending
//   grant_owner   : requester chosen when grant_valid
// -----------------------------------------------------------------------------
module arb_grant
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
`ifdef ARB_STARVE_GUARD_EN
  input  logic   clock,
  input  logic   reset,
`endif
  input  logic   inst_req,
  input  logic   data_req,
  input  logic   grant_en,
  output logic   grant_valid,
  output owner_e grant_owner
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("arb_grant: STARVE_LIMIT must be at least 1");
  end

  assign grant_valid = inst_req | data_req;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = starve_cnt_w(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples its inputs from before the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst_req) begin
      starve_cnt <= '0;
    end else if (grant_en && grant_valid) begin
      if (grant_owner == OWN_INST) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    // Data wins unless a waiting fetch has been passed over too many times.
    if (data_req && !(starved && inst_req)) begin
      grant_owner = OWN_DATA;
    end else if (inst_req) begin
      grant_owner = OWN_INST;
    end else begin
      grant_owner = OWN_DATA;
    end
  end

  logic unused_grant_en;
  assign unused_grant_en = 1'b0;
`else
  always_comb begin
    if (data_req) begin
      grant_owner = OWN_DATA;
    end else if (inst_req) begin
      grant_owner = OWN_INST;
    end else begin
      grant_owner = OWN_DATA;
    end
  end

  // Without the starvation guard the decision is purely combinational; the
  // arbitration strobe is kept in the interface so both builds share a port.
  logic unused_grant_en;
  assign unused_grant_en = grant_en;
`endif

endmodule : arb_grant

// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
// Shares one sram-like memory port (towards the AXI bridge) between the
// instruction-fetch requester and the data-memory requester. Fixed priority
// data over inst, one outstanding transaction at a time. addr_ok / data_ok /
// rdata are routed back to the owner. An accepted fetch can be cancelled
// (exception / branch redirect); its response is then swallowed.
//
// Optional feature: define ARB_STARVE_GUARD_EN to force a waiting fetch
// through after STARVE_LIMIT consecutive data grants.
//
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata     : fetch request (held until inst_addr_ok)
//   inst_cancel                     : pulse, discard the in-flight fetch
//   inst_addr_ok/data_ok/rdata      : fetch handshakes and read data
//   data_req/wr/size/addr/wdata     : data request (held until data_addr_ok)
//   data_addr_ok/data_ok/rdata      : data handshakes and load data
//   mem_req/wr/size/addr/wdata      : shared downstream request
//   mem_addr_ok/data_ok/rdata       : downstream handshakes and read data
// -----------------------------------------------------------------------------
module sram_req_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state, state_next;
  owner_e     owner, owner_next;
  logic       drop, drop_next;

  logic       grant_en;
  logic       grant_valid;
  owner_e     grant_owner;
  logic       cancel_hit;
  logic       drop_eff;

  // Arbitration happens from IDLE, or when the current response completes so
  // a pending request can be issued without an IDLE bubble.
  assign grant_en = (state == IDLE) || (state == RESP && mem_data_ok);

  arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
`ifdef ARB_STARVE_GUARD_EN
    .clock      (clock),
    .reset      (reset),
`endif
    .inst_req   (inst_req),
    .data_req   (data_req),
    .grant_en   (grant_en),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  // A cancel only matters for a fetch that owns the port; it is ignored while
  // a data transaction is in flight.
  assign cancel_hit = (owner == OWN_INST) && inst_cancel;
  assign drop_eff   = drop || cancel_hit;

  // Request fields follow the owner; mem_req alone qualifies them.
  assign mem_wr    = (owner == OWN_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (owner == OWN_DATA) ? data_size  : inst_size;
  assign mem_addr  = (owner == OWN_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (owner == OWN_DATA) ? data_wdata : inst_wdata;

  // Read data is a pass-through; each side qualifies it with its own data_ok.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_INST;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      drop  <= drop_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    owner_next   = owner;
    drop_next    = drop;
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          owner_next = grant_owner;
          state_next = REQ;
        end
      end

      REQ: begin
        mem_req      = 1'b1;
        inst_addr_ok = (owner == OWN_INST) && mem_addr_ok;
        data_addr_ok = (owner == OWN_DATA) && mem_addr_ok;
        if (mem_addr_ok) begin
          state_next = RESP;
          // Cancel before the address handshake is meaningless: the fetch
          // unit simply retargets its held request.
          if (cancel_hit) begin
            drop_next = 1'b1;
          end
        end
      end

      RESP: begin
        if (mem_data_ok) begin
          inst_data_ok = (owner == OWN_INST) && !drop_eff;
          data_data_ok = (owner == OWN_DATA);
          drop_next    = 1'b0;
          if (grant_valid) begin
            owner_next = grant_owner;
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end else if (cancel_hit) begin
          drop_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule : sram_req_arbiter

// File: tb/tb_sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_req_arbiter
// Directed bench for sram_req_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_sram_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          inst_req, inst_wr, inst_cancel;
  logic [1:0]    inst_size;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_wdata;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_req, mem_wr;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok, mem_data_ok;
  logic [DW-1:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  sram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_wr     (inst_wr),
    .inst_size   (inst_size),
    .inst_addr   (inst_addr),
    .inst_wdata  (inst_wdata),
    .inst_cancel (inst_cancel),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  task automatic cycle();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b10; inst_addr = '0; inst_wdata = '0;
    inst_cancel = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b10; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cycle(); cycle();
    reset = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_tests++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_handshakes: got %b want 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
  endtask

  task automatic test_single_fetch();
    cycle(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'b10; #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_latency: mem_req got %b want 0", mem_req); end
    cycle(); mem_addr_ok = 1'b1; #1;
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_req: got %b want 1", mem_req); end
    n_tests++; if (mem_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL fetch_mem_addr: got %h want bfc00000", mem_addr); end
    n_tests++; if (mem_size !== 2'b10) begin n_fail++; $display("FAIL fetch_mem_size: got %b want 10", mem_size); end
    n_tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL fetch_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok}); end
    cycle(); inst_req = 1'b0; mem_addr_ok = 1'b0; #1;
    n_tests++; if ({mem_req, inst_data_ok} !== 2'b00) begin n_fail++; $display("FAIL fetch_resp_wait: got %b want 00", {mem_req, inst_data_ok}); end
    cycle(); mem_data_ok = 1'b1; mem_rdata = 32'h3C08_0001; #1;
    n_tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL fetch_data_ok: got %b want 10", {inst_data_ok, data_data_ok}); end
    n_tests++; if (inst_rdata !== 32'h3C08_0001) begin n_fail++; $display("FAIL fetch_rdata: got %h want 3c080001", inst_rdata); end
    cycle(); mem_data_ok = 1'b0; #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_back_idle: mem_req got %b want 0", mem_req); end
  endtask

  task automatic test_collision();
    cycle();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
    cycle(); mem_addr_ok = 1'b1; #1;
    n_tests++; if ({mem_req, mem_wr} !== 2'b11) begin n_fail++; $display("FAIL coll_data_first: req/wr got %b want 11", {mem_req, mem_wr}); end
    n_tests++; if (mem_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL coll_data_addr: got %h want 80001000", mem_addr); end
    n_tests++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL coll_wdata: got %h want deadbeef", mem_wdata); end
    n_tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_fail++; $display("FAIL coll_addr_ok: got %b want 01", {inst_addr_ok, data_addr_ok}); end
    cycle(); data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0;
    cycle(); mem_data_ok = 1'b1; #1;
    n_tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL coll_data_ok: got %b want 01", {inst_data_ok, data_data_ok}); end
    cycle(); mem_data_ok = 1'b0; mem_addr_ok = 1'b1; #1;
    n_tests++; if ({mem_req, mem_wr} !== 2'b10) begin n_fail++; $display("FAIL coll_inst_no_bubble: req/wr got %b want 10", {mem_req, mem_wr}); end
    n_tests++; if (mem_addr !== 32'hBFC0_0010) begin n_fail++; $display("FAIL coll_inst_addr: got %h want bfc00010", mem_addr); end
    n_tests++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL coll_inst_addr_ok: got %b want 1", inst_addr_ok); end
    cycle(); inst_req = 1'b0; mem_addr_ok = 1'b0;
    cycle(); mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678; #1;
    n_tests++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL coll_inst_data_ok: got %b want 1", inst_data_ok); end
    cycle(); mem_data_ok = 1'b0;
  endtask

  task automatic test_cancel();
    // Cancel during REQ before addr_ok is ignored; the second cancel in RESP drops.
    cycle(); inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    cycle(); inst_cancel = 1'b1; #1;
    n_tests++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL cancel_wait_addr: got %b want 0", inst_addr_ok); end
    cycle(); inst_cancel = 1'b0; mem_addr_ok = 1'b1;
    cycle(); inst_req = 1'b0; mem_addr_ok = 1'b0; inst_cancel = 1'b1;
    cycle(); inst_cancel = 1'b0;
    cycle(); mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_5555; #1;
    n_tests++; if (inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL cancel_swallow: inst_data_ok got %b want 0", inst_data_ok); end
    cycle(); mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0380;
    cycle(); mem_addr_ok = 1'b1; #1;
    n_tests++; if (mem_addr !== 32'hBFC0_0380) begin n_fail++; $display("FAIL cancel_next_addr: got %h want bfc00380", mem_addr); end
    cycle(); inst_req = 1'b0; mem_addr_ok = 1'b0;
    cycle(); mem_data_ok = 1'b1; mem_rdata = 32'h0000_0380; #1;
    n_tests++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL cancel_next_data_ok: got %b want 1", inst_data_ok); end
    n_tests++; if (inst_rdata !== 32'h0000_0380) begin n_fail++; $display("FAIL cancel_next_rdata: got %h want 00000380", inst_rdata); end
    cycle(); mem_data_ok = 1'b0;
  endtask

  task automatic test_cancel_edges();
    // Cancel coincident with mem_data_ok.
    cycle(); inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    cycle(); mem_addr_ok = 1'b1;
    cycle(); inst_req = 1'b0; mem_addr_ok = 1'b0;
    cycle(); mem_data_ok = 1'b1; inst_cancel = 1'b1; #1;
    n_tests++; if (inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL cancel_coincident: got %b want 0", inst_data_ok); end
    // Cancel while data owns the port must not drop the load.
    cycle(); mem_data_ok = 1'b0; inst_cancel = 1'b0; data_req = 1'b1; data_addr = 32'h8000_2000;
    cycle(); mem_addr_ok = 1'b1; inst_cancel = 1'b1;
    cycle(); data_req = 1'b0; mem_addr_ok = 1'b0;
    cycle(); mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
    n_tests++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL cancel_data_owner: data_data_ok got %b want 1", data_data_ok); end
    n_tests++; if (data_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL cancel_data_rdata: got %h want cafef00d", data_rdata); end
    cycle(); mem_data_ok = 1'b0; inst_cancel = 1'b0;
  endtask

  task automatic test_reset_mid();
    cycle(); inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
    cycle(); mem_addr_ok = 1'b1;
    cycle(); inst_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1;
    cycle(); reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_req: got %b want 0", mem_req); end
    n_tests++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_handshakes: got %b want 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
    cycle(); mem_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h8000_3000; #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got %b want 0", mem_req); end
    cycle(); mem_addr_ok = 1'b1; #1;
    n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_addr_ok: got %b want 1", data_addr_ok); end
    cycle(); data_req = 1'b0; mem_addr_ok = 1'b0;
    cycle(); mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D; #1;
    n_tests++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_data_ok: got %b want 1", data_data_ok); end
    cycle(); mem_data_ok = 1'b0;
  endtask

  task automatic test_starvation();
    int   grants = 0;
    logic pend   = 1'b0;
    logic got_inst, want_inst;
    cycle();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0400;
    data_req = 1'b1; data_addr = 32'h8000_4000;
    for (int c = 0; c < 200 && grants < 10; c++) begin
      cycle();
      mem_data_ok = pend; mem_addr_ok = 1'b0; pend = 1'b0;
      #1;
      if (mem_req) begin
        mem_addr_ok = 1'b1;
        pend        = 1'b1;
        got_inst    = (mem_addr == 32'hBFC0_0400);
`ifdef ARB_STARVE_GUARD_EN
        want_inst   = ((grants % 5) == 4);
`else
        want_inst   = 1'b0;
`endif
        n_tests++;
        if (got_inst !== want_inst) begin
          n_fail++; $display("FAIL starve_grant_%0d: inst granted %b want %b", grants, got_inst, want_inst);
        end
        grants++;
      end
    end
    n_tests++; if (grants != 10) begin n_fail++; $display("FAIL starve_timeout: grants %0d want 10", grants); end
    cycle(); mem_addr_ok = 1'b0; mem_data_ok = pend; inst_req = 1'b0; data_req = 1'b0;
    cycle(); mem_data_ok = 1'b0; #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL starve_drain: mem_req got %b want 0", mem_req); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_collision();
    test_cancel();
    test_cancel_edges();
    test_reset_mid();
    test_starvation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sram_req_arbiter
